csa_mac_accumulator: RTL and testbench



---
 rtl/csa_mac_pkg.sv | 29 ++
 rtl/csa_mac_accumulator_if.sv | 29 ++
 rtl/csa_resolve.sv | 12 +
 rtl/csa_mac_accumulator.sv | 124 ++++++++++++
 tb/tb_csa_mac_accumulator.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_mac_pkg.sv
// Shared types, widths and helpers for the carry-save MAC accumulator slice.
// Helpers return 32-bit patterns; callers size-cast them to their accumulator width.
package csa_mac_pkg;

    localparam int CS_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    function automatic logic [31:0] sext8(input logic [CS_W-1:0] p, input int acc_w);
        logic [31:0] r;
        r = {{(32-CS_W){p[CS_W-1]}}, p};
        if (acc_w < 32) begin
            r = r & ((32'd1 << acc_w) - 32'd1);
        end
        return r;
    endfunction

    function automatic logic [31:0] acc_max(input int acc_w);
        return (32'd1 << (acc_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] acc_min(input int acc_w);
        return 32'd1 << (acc_w - 1);
    endfunction

endpackage

// File: rtl/csa_mac_accumulator_if.sv
// Beat input and frame-result output of the MAC accumulator, one valid/ready pair each.
// master = producer/consumer side, slave = the accumulator.
interface csa_mac_accumulator_if
    import csa_mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic [CS_W-1:0]  cs_a;
    logic [CS_W-1:0]  cs_b;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] n_terms;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output cs_a, cs_b, in_valid, in_last, out_ready,
        input  in_ready, acc_out, n_terms, ovf, out_valid
    );

    modport slave (
        input  cs_a, cs_b, in_valid, in_last, out_ready,
        output in_ready, acc_out, n_terms, ovf, out_valid
    );
endinterface

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair into a two's-complement word (carry out dropped).
// Latency: combinational.
// Backpressure: none; pure datapath, kept separate so a faster adder can drop in.
module csa_resolve
    import csa_mac_pkg::*;
(
    input  logic [CS_W-1:0] a,
    input  logic [CS_W-1:0] b,
    output logic [CS_W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/csa_mac_accumulator.sv
// Resolves carry-save products and sums them per in_last-delimited frame (CSA_MAC_SATURATE_EN clamps).
// Latency: last beat accepted at edge t -> out_valid after edge t+1; one beat per cycle.
// Backpressure: single global stall, in_ready = !out_valid || out_ready; stalled pipeline holds.
module csa_mac_accumulator
    import csa_mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    csa_mac_accumulator_if.slave  bus
);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] n_terms;
        logic             ovf;
    } res_t;

    logic             en;
    logic             accept;
    logic [CS_W-1:0]  p_res;

    logic [CS_W-1:0]  p1;
    logic             last1;
    logic             v1;

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_run;

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_now;

    res_t             res_q;
    logic             out_valid_q;

    assign en     = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && en;

    csa_resolve u_resolve (
        .a   (bus.cs_a),
        .b   (bus.cs_b),
        .sum (p_res)
    );

    assign addend  = ACC_W'(sext8(p1, ACC_W));
    assign base    = (state == IDLE) ? '0 : acc;
    assign sum_raw = base + addend;
    assign ovf_now = (base[ACC_W-1] == addend[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != base[ACC_W-1]);

`ifdef CSA_MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

    always_comb begin
        sum = sum_raw;
        if (ovf_now) begin
            sum = addend[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = sum_raw;
`endif

    // Term count sticks at all-ones; saturation is not an arithmetic overflow.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1          <= '0;
            last1       <= 1'b0;
            v1          <= 1'b0;
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf_run     <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (en) begin
                p1    <= p_res;
                last1 <= bus.in_last;
                v1    <= accept;
                if (v1) begin
                    if (last1) begin
                        res_q   <= '{sum: sum, n_terms: cnt_inc, ovf: ovf_run | ovf_now};
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_run <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        acc     <= sum;
                        cnt     <= cnt_inc;
                        ovf_run <= ovf_run | ovf_now;
                        state   <= ACC;
                    end
                end
            end

            // A result loading in the same cycle as a consume keeps out_valid high.
            if (en && v1 && last1) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = res_q.sum;
    assign bus.n_terms   = res_q.n_terms;
    assign bus.ovf       = res_q.ovf;

endmodule

// File: tb/tb_csa_mac_accumulator.sv
// Bench for csa_mac_accumulator: directed frames plus random traffic, scoreboarded
// against an integer-arithmetic frame model.
module tb_csa_mac_accumulator;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam int VMAX  = (1 << (ACC_W - 1)) - 1;
    localparam int VMIN  = -(1 << (ACC_W - 1));
    localparam int NMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_mac_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dif ();

    csa_mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        int sum;
        int n;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_sum = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    bit               prev_hold = 1'b0;
    logic [ACC_W-1:0] prev_acc;
    logic [CNT_W-1:0] prev_n;
    logic             prev_ovf;
    bit               rnd_on = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int prod8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return int'($signed(s));
    endfunction

    // Frame model: true integer sum, then wrap or clamp into the signed ACC_W range.
    task automatic model_beat(input int p, input bit last);
        int raw;
        raw = m_sum + p;
        if (raw > VMAX || raw < VMIN) begin
            m_ovf = 1'b1;
`ifdef CSA_MAC_SATURATE_EN
            raw = (raw > VMAX) ? VMAX : VMIN;
`else
            raw = (raw > VMAX) ? raw - (1 << ACC_W) : raw + (1 << ACC_W);
`endif
        end
        m_sum = raw;
        if (m_cnt < NMAX) m_cnt++;
        if (last) begin
            exp_q.push_back('{sum: m_sum, n: m_cnt, ovf: m_ovf});
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
    endtask

    // Monitor: outputs and handshakes are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_acc_out", dif.acc_out, prev_acc);
                check("hold_n_terms", dif.n_terms, prev_n);
                check("hold_ovf", dif.ovf, prev_ovf);
            end
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got acc_out=%0d, expected no result", $signed(dif.acc_out));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("acc_out", int'($signed(dif.acc_out)), e.sum);
                    check("n_terms", dif.n_terms, e.n);
                    check("ovf", dif.ovf, e.ovf);
                end
            end
            prev_hold = dif.out_valid && !dif.out_ready;
            prev_acc  = dif.acc_out;
            prev_n    = dif.n_terms;
            prev_ovf  = dif.ovf;
            if (dif.in_valid && dif.in_ready) begin
                model_beat(prod8(dif.cs_a, dif.cs_b), dif.in_last);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        dif.cs_a     = a;
        dif.cs_b     = b;
        dif.in_last  = last;
        dif.in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = dif.in_ready;
            @(posedge clk);
            #1;
        end
        dif.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.cs_a      = '0;
        dif.cs_b      = '0;
        dif.in_valid  = 1'b0;
        dif.in_last   = 1'b0;
        dif.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", dif.in_ready, 1);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_acc_out", dif.acc_out, 0);
        check("rst_n_terms", dif.n_terms, 0);
        check("rst_ovf", dif.ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-beat frame: 0x30+0x10 = 64, result visible one edge after the accept edge.
        send(8'h30, 8'h10, 1'b1);
        @(negedge clk);
        check("lat_after_t", dif.out_valid, 0);
        @(negedge clk);
        check("lat_after_t1", dif.out_valid, 1);
        @(posedge clk);
        #1;

        // 64, -60, 15, -16 back to back -> 3, then a fresh frame from zero.
        send(8'h30, 8'h10, 1'b0);
        send(8'hC4, 8'h00, 1'b0);
        send(8'h0F, 8'h00, 1'b0);
        send(8'hF0, 8'h00, 1'b1);
        send(8'h05, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: pending result blocks input, release consumes and accepts together.
        dif.out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        dif.cs_a     = 8'h03;
        dif.cs_b     = 8'h00;
        dif.in_last  = 1'b1;
        dif.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", dif.in_ready, 0);
        end
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", dif.in_ready, 1);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Long frame of 64s: wraps past the ACC_W range and saturates the term count.
        for (int i = 0; i < 600; i++) begin
            send(8'h30, 8'h10, (i == 599));
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-frame discards the partial sum.
        send(8'h30, 8'h10, 1'b0);
        send(8'h0F, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", dif.out_valid, 0);
        send(8'h0F, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Random traffic with random consumer backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [7:0] a;
                    int         p;
                    p = int'($urandom_range(0, 124)) - 60;
                    a = 8'($urandom);
                    send(a, 8'(p) - a, ($urandom_range(0, 4) == 0) || (i == 399));
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 dif.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        dif.out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
